// File: rtl/servo_pos_ctrl.sv
// -----------------------------------------------------------------------------
// servo_pos_ctrl
//
// Front end of the servo PWM generator. The raw open/close request from the
// pad is synchronised into the clk domain and debounced. The debounced level
// selects a target position word, and the output position slews toward that
// target by at most STEP per servo frame, so the servo never jumps.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active high
//   open_in    in   1   raw pad level, 1 = open, 0 = close (asynchronous to clk)
//   pos        out  18  pulse-width position word for the PWM divider
//   req        out  1   debounced request level
//   frame_tick out  1   one-cycle pulse on the last cycle of every frame
//   moving     out  1   pos differs from the current target
//   at_target  out  1   pos equals the current target (inverse of moving)
// -----------------------------------------------------------------------------
module servo_pos_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 120000,
    parameter int          FRAME_CYCLES    = 240000,
    parameter logic [17:0] POS_CLOSE       = 18'd12000,
    parameter logic [17:0] POS_OPEN        = 18'd24000,
    parameter logic [17:0] STEP            = 18'd600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        open_in,
    output logic [17:0] pos,
    output logic        req,
    output logic        frame_tick,
    output logic        moving,
    output logic        at_target
);

    localparam int                  DCNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0]   DCNT_ONE  = DCNT_W'(1);
    localparam logic [17:0]         FCNT_LAST = 18'(FRAME_CYCLES - 1);

    // One slew step from cur toward tgt, clamped so the result never passes
    // tgt. The distance to the target is compared against STEP instead of
    // forming cur-STEP first, so nothing can wrap below zero; the 19-bit
    // add keeps cur+STEP from wrapping at 2^18.
    function automatic logic [17:0] slew_step(input logic [17:0] cur,
                                              input logic [17:0] tgt);
        logic [18:0] cur_w;
        logic [18:0] tgt_w;
        logic [18:0] step_w;
        logic [18:0] sum_w;
        logic [18:0] dif_w;
        logic [17:0] res;
        cur_w  = {1'b0, cur};
        tgt_w  = {1'b0, tgt};
        step_w = {1'b0, STEP};
        res    = cur;
        if (cur_w < tgt_w) begin
            dif_w = tgt_w - cur_w;
            sum_w = cur_w + step_w;
            res   = (dif_w <= step_w) ? tgt : sum_w[17:0];
        end else if (cur_w > tgt_w) begin
            dif_w = cur_w - tgt_w;
            sum_w = cur_w - step_w;
            res   = (dif_w <= step_w) ? tgt : sum_w[17:0];
        end
        return res;
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DCNT_W-1:0] dcnt_q,  dcnt_d;
    logic              req_q,   req_d;
    logic [17:0]       fcnt_q,  fcnt_d;
    logic              frame_tick_q, frame_tick_d;
    logic [17:0]       pos_q,   pos_d;

    logic [17:0]       tgt;
    logic              tick;

    // Target follows the debounced register directly, so a req change and a
    // tick in the same cycle still step toward the old target.
    assign tgt  = req_q ? POS_OPEN : POS_CLOSE;
    assign tick = (fcnt_q == FCNT_LAST);

    always_comb begin
        // Synchroniser stage
        sync1_d = open_in;
        sync2_d = sync1_q;

        // Debounce stage
        dcnt_d = dcnt_q;
        req_d  = req_q;
        if (sync2_q == req_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            req_d  = sync2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
        end

        // Frame pacing stage; frame_tick is registered from the next count
        // so it is high during the cycle the counter sits on its last value.
        fcnt_d       = tick ? 18'd0 : (fcnt_q + 18'd1);
        frame_tick_d = (fcnt_d == FCNT_LAST);

        // Slew stage
        pos_d = tick ? slew_step(pos_q, tgt) : pos_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dcnt_q       <= '0;
            req_q        <= 1'b0;
            fcnt_q       <= 18'd0;
            frame_tick_q <= 1'b0;
            pos_q        <= POS_CLOSE;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            dcnt_q       <= dcnt_d;
            req_q        <= req_d;
            fcnt_q       <= fcnt_d;
            frame_tick_q <= frame_tick_d;
            pos_q        <= pos_d;
        end
    end

    assign pos        = pos_q;
    assign req        = req_q;
    assign frame_tick = frame_tick_q;
    assign moving     = (pos_q != tgt);
    assign at_target  = (pos_q == tgt);

endmodule

// File: tb/tb_servo_pos_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servo_pos_ctrl
//
// Bench for servo_pos_ctrl with DEBOUNCE_CYCLES=4, FRAME_CYCLES=10,
// POS_CLOSE=100, POS_OPEN=130, STEP=8. Time t counts clock edges since the
// latest reset release; outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_servo_pos_ctrl;

    logic        clk;
    logic        rst;
    logic        open_in;
    logic [17:0] pos;
    logic        req;
    logic        frame_tick;
    logic        moving;
    logic        at_target;

    int checks   = 0;
    int failures = 0;

    servo_pos_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FRAME_CYCLES   (10),
        .POS_CLOSE      (18'd100),
        .POS_OPEN       (18'd130),
        .STEP           (18'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .open_in   (open_in),
        .pos       (pos),
        .req       (req),
        .frame_tick(frame_tick),
        .moving    (moving),
        .at_target (at_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        open_v;
        int          ncyc;
        logic [17:0] pos;
        logic        req;
        logic        tick;
        logic        at;
    } vec_t;

    typedef struct {
        string       name;
        logic [17:0] pos;
        logic        req;
        logic        tick;
        logic        at;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input int p, input logic r,
                            input logic t, input logic a);
        exp_t e;
        e.name = name;
        e.pos  = 18'(p);
        e.req  = r;
        e.tick = t;
        e.at   = a;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            check_int({e.name, ".pos"}, int'(pos), int'(e.pos));
            check_bit({e.name, ".req"}, req, e.req);
            check_bit({e.name, ".tick"}, frame_tick, e.tick);
            check_bit({e.name, ".at_target"}, at_target, e.at);
            check_bit({e.name, ".moving"}, moving, ~e.at);
        end
    endtask

    task automatic add_row(input logic o, input int n, input int p, input logic r,
                           input logic t, input logic a);
        vec_t v;
        v.open_v = o;
        v.ncyc   = n;
        v.pos    = 18'(p);
        v.req    = r;
        v.tick   = t;
        v.at     = a;
        tbl.push_back(v);
    endtask

    initial begin
        int ticks_seen;
        int last_rise;
        int prev_tick;

        // Open ramp with clamp at 130, close ramp with clamp at 100,
        // 3-cycle glitch rejected, 6-cycle pulse accepted and released.
        add_row(1,  5, 100, 0, 0, 1);  // t=5
        add_row(1,  1, 100, 1, 0, 0);  // t=6   req after 2+4
        add_row(1,  3, 100, 1, 1, 0);  // t=9   first frame_tick
        add_row(1,  1, 108, 1, 0, 0);  // t=10
        add_row(1,  9, 108, 1, 1, 0);  // t=19
        add_row(1,  1, 116, 1, 0, 0);  // t=20
        add_row(1, 10, 124, 1, 0, 0);  // t=30
        add_row(1, 10, 130, 1, 0, 1);  // t=40  124+8 clamped
        add_row(1, 10, 130, 1, 0, 1);  // t=50  holds
        add_row(0,  5, 130, 1, 0, 1);  // t=55
        add_row(0,  1, 130, 0, 0, 0);  // t=56  req drops, moving
        add_row(0,  4, 122, 0, 0, 0);  // t=60
        add_row(0, 10, 114, 0, 0, 0);  // t=70
        add_row(0, 10, 106, 0, 0, 0);  // t=80
        add_row(0, 10, 100, 0, 0, 1);  // t=90  106-8 clamped
        add_row(0, 10, 100, 0, 0, 1);  // t=100
        add_row(1,  3, 100, 0, 0, 1);  // t=103 3-cycle pulse
        add_row(0,  7, 100, 0, 0, 1);  // t=110 rejected
        add_row(1,  6, 100, 1, 0, 0);  // t=116 6-cycle pulse accepted
        add_row(0,  4, 108, 1, 0, 0);  // t=120 tick toward 130
        add_row(0,  2, 108, 0, 0, 0);  // t=122 req back to 0
        add_row(0,  8, 100, 0, 0, 1);  // t=130

        // Reset held for 3 cycles with open_in high
        rst     = 1'b1;
        open_in = 1'b1;
        #2;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_int($sformatf("reset%0d.pos", c), int'(pos), 100);
            check_bit($sformatf("reset%0d.req", c), req, 1'b0);
            check_bit($sformatf("reset%0d.at_target", c), at_target, 1'b1);
            check_bit($sformatf("reset%0d.moving", c), moving, 1'b0);
            check_bit($sformatf("reset%0d.tick", c), frame_tick, 1'b0);
        end
        rst = 1'b0;

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < tbl.size(); i++) begin
            open_in = tbl[i].open_v;
            push_exp($sformatf("row%0d", i), int'(tbl[i].pos), tbl[i].req,
                     tbl[i].tick, tbl[i].at);
            step(tbl[i].ncyc);
            pop_compare();
        end

        // Async reset mid-ramp at pos=124
        open_in = 1'b1;
        step(30);                                      // t=160
        push_exp("premid", 124, 1'b1, 1'b0, 1'b0);
        pop_compare();
        #3;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 100, 1'b0, 1'b0, 1'b1);
        pop_compare();
        step(2);
        rst = 1'b0;

        // Frame counter restarts: first tick sampled after edge 9
        for (int t = 1; t <= 20; t++) begin
            step(1);
            check_bit($sformatf("restart_t%0d.tick", t), frame_tick,
                      (t == 9) || (t == 19));
            if (t == 10) begin
                push_exp("restart_t10", 108, 1'b1, 1'b0, 1'b0);
                pop_compare();
            end
        end

        // Reversal at pos=116 (t=20)
        push_exp("rev_t20", 116, 1'b1, 1'b0, 1'b0);
        pop_compare();
        open_in = 1'b0;
        push_exp("rev_t25", 116, 1'b1, 1'b0, 1'b0);
        step(5);
        pop_compare();
        push_exp("rev_t26", 116, 1'b0, 1'b0, 1'b0);
        step(1);
        pop_compare();
        push_exp("rev_t30", 108, 1'b0, 1'b0, 1'b0);
        step(4);
        pop_compare();
        push_exp("rev_t40", 100, 1'b0, 1'b0, 1'b1);
        step(10);
        pop_compare();
        push_exp("rev_t50", 100, 1'b0, 1'b0, 1'b1);
        step(10);
        pop_compare();

        // Frame pacing over 100 free-running cycles
        ticks_seen = 0;
        last_rise  = -1;
        prev_tick  = 0;
        for (int c = 1; c <= 100; c++) begin
            step(1);
            if (frame_tick === 1'b1) begin
                if (prev_tick == 1) begin
                    check_int($sformatf("pace_c%0d.width", c), 2, 1);
                end else begin
                    ticks_seen++;
                    if (last_rise >= 0)
                        check_int($sformatf("pace_c%0d.period", c), c - last_rise, 10);
                    last_rise = c;
                end
                prev_tick = 1;
            end else begin
                prev_tick = 0;
            end
        end
        check_int("pace.count", ticks_seen, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
